// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue register for the EX ALU. Operand forwarding is added by ALU_ISSUE_FORWARD_EN.
// Latency 1 cycle. A mul is held for MUL_LATENCY cycles with busy_o asking upstream to stall; stall_i holds the entry.
module alu_issue_stage #(
    parameter int MUL_LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [1:0]  ALUOp_i,
    input  logic [5:0]  funct_i,
    input  logic        ALUSrc_i,
    input  logic [31:0] RSdata_i,
    input  logic [31:0] RTdata_i,
    input  logic [31:0] imm_i,
`ifdef ALU_ISSUE_FORWARD_EN
    input  logic [1:0]  fwdA_i,
    input  logic [1:0]  fwdB_i,
    input  logic [31:0] EXMEM_data_i,
    input  logic [31:0] MEMWB_data_i,
`endif
    output logic [31:0] data1_o,
    output logic [31:0] data2_o,
    output logic [2:0]  ALUCtrl_o,
    output logic [31:0] RTdata_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        illegal_o
);

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_SUB = 3'b011;
    localparam logic [2:0] CTRL_MUL = 3'b100;

    // A single-cycle mul never opens a hold window.
    localparam logic [3:0] MUL_CNT_INIT = (MUL_LATENCY > 1) ? 4'(MUL_LATENCY - 1) : 4'd0;

    logic [2:0]  enc_ctrl;
    logic        enc_illegal;

    logic        valid_q,   valid_d;
    logic [2:0]  ctrl_q,    ctrl_d;
    logic        illegal_q, illegal_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [31:0] rs_q,      rs_d;
    logic [31:0] rt_q,      rt_d;
`ifdef ALU_ISSUE_FORWARD_EN
    logic [31:0] imm_q,     imm_d;
    logic        alusrc_q,  alusrc_d;
    logic [31:0] rs_fwd;
    logic [31:0] rt_fwd;
`else
    logic [31:0] op2_q,     op2_d;
`endif

    logic busy;
    logic hold;

    assign busy = (cnt_q != 4'd0);
    assign hold = stall_i | busy;

    always_comb begin
        enc_ctrl    = CTRL_ADD;
        enc_illegal = 1'b0;
        case (ALUOp_i)
            2'b00: enc_ctrl = CTRL_ADD;
            2'b01: enc_ctrl = CTRL_SUB;
            2'b10: begin
                case (funct_i)
                    6'h24:   enc_ctrl = CTRL_AND;
                    6'h25:   enc_ctrl = CTRL_OR;
                    6'h20:   enc_ctrl = CTRL_ADD;
                    6'h22:   enc_ctrl = CTRL_SUB;
                    6'h18:   enc_ctrl = CTRL_MUL;
                    default: enc_illegal = 1'b1;
                endcase
            end
            default: enc_illegal = 1'b1;
        endcase
    end

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
`ifdef ALU_ISSUE_FORWARD_EN
        imm_d     = imm_q;
        alusrc_d  = alusrc_q;
`else
        op2_d     = op2_q;
`endif
        // The mul window keeps counting down even while the entry is stalled.
        cnt_d     = busy ? (cnt_q - 4'd1) : cnt_q;

        if (flush_i) begin
            valid_d   = 1'b0;
            ctrl_d    = CTRL_AND;
            illegal_d = 1'b0;
            cnt_d     = 4'd0;
        end else if (!hold) begin
            valid_d   = valid_i;
            ctrl_d    = valid_i ? enc_ctrl : CTRL_AND;
            illegal_d = valid_i & enc_illegal;
            rs_d      = RSdata_i;
            rt_d      = RTdata_i;
`ifdef ALU_ISSUE_FORWARD_EN
            imm_d     = imm_i;
            alusrc_d  = ALUSrc_i;
`else
            op2_d     = ALUSrc_i ? imm_i : RTdata_i;
`endif
            cnt_d     = (valid_i && (enc_ctrl == CTRL_MUL)) ? MUL_CNT_INIT : 4'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_AND;
            illegal_q <= 1'b0;
            cnt_q     <= 4'd0;
            rs_q      <= 32'd0;
            rt_q      <= 32'd0;
`ifdef ALU_ISSUE_FORWARD_EN
            imm_q     <= 32'd0;
            alusrc_q  <= 1'b0;
`else
            op2_q     <= 32'd0;
`endif
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
`ifdef ALU_ISSUE_FORWARD_EN
            imm_q     <= imm_d;
            alusrc_q  <= alusrc_d;
`else
            op2_q     <= op2_d;
`endif
        end
    end

`ifdef ALU_ISSUE_FORWARD_EN
    // Select code 11 falls back to the registered value, same as 00.
    always_comb begin
        case (fwdA_i)
            2'b10:   rs_fwd = EXMEM_data_i;
            2'b01:   rs_fwd = MEMWB_data_i;
            default: rs_fwd = rs_q;
        endcase
        case (fwdB_i)
            2'b10:   rt_fwd = EXMEM_data_i;
            2'b01:   rt_fwd = MEMWB_data_i;
            default: rt_fwd = rt_q;
        endcase
    end

    assign data1_o  = rs_fwd;
    assign data2_o  = alusrc_q ? imm_q : rt_fwd;
    assign RTdata_o = rt_fwd;
`else
    assign data1_o  = rs_q;
    assign data2_o  = op2_q;
    assign RTdata_o = rt_q;
`endif

    assign ALUCtrl_o = ctrl_q;
    assign valid_o   = valid_q;
    assign illegal_o = illegal_q;
    assign busy_o    = busy;
    assign done_o    = valid_q & ~busy;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed test-plan steps, then random traffic against a reference model.
module tb_alu_issue_stage;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, stall_i, flush_i, ALUSrc_i;
    logic [1:0]  ALUOp_i;
    logic [5:0]  funct_i;
    logic [31:0] RSdata_i, RTdata_i, imm_i;
    logic [31:0] data1_o, data2_o, RTdata_o;
    logic [2:0]  ALUCtrl_o;
    logic        valid_o, busy_o, done_o, illegal_o;
`ifdef ALU_ISSUE_FORWARD_EN
    logic [1:0]  fwdA_i, fwdB_i;
    logic [31:0] EXMEM_data_i, MEMWB_data_i;
`endif

    always #5 clk = ~clk;

    alu_issue_stage #(.MUL_LATENCY(L)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .ALUOp_i(ALUOp_i), .funct_i(funct_i), .ALUSrc_i(ALUSrc_i),
        .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .imm_i(imm_i),
`ifdef ALU_ISSUE_FORWARD_EN
        .fwdA_i(fwdA_i), .fwdB_i(fwdB_i), .EXMEM_data_i(EXMEM_data_i), .MEMWB_data_i(MEMWB_data_i),
`endif
        .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(ALUCtrl_o), .RTdata_o(RTdata_o),
        .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o), .illegal_o(illegal_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the EX entry plus the age of a mul since it was loaded.
    logic        m_valid, m_ill;
    logic [2:0]  m_ctrl;
    logic [31:0] m_d1, m_d2, m_rt;
    bit          m_known, m_window;
    int          m_age;

    function automatic logic [3:0] ref_encode(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd0) return 4'b0_010;
        if (op == 2'd1) return 4'b0_011;
        if (op == 2'd2) begin
            if (f == 6'h24) return 4'b0_000;
            if (f == 6'h25) return 4'b0_001;
            if (f == 6'h20) return 4'b0_010;
            if (f == 6'h22) return 4'b0_011;
            if (f == 6'h18) return 4'b0_100;
        end
        return 4'b1_010;
    endfunction

    function automatic bit m_busy();
        return m_window && (m_age < L - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit b;
        b = m_busy();
        chk("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
        chk("ALUCtrl_o", {29'd0, ALUCtrl_o}, {29'd0, m_ctrl});
        chk("illegal_o", {31'd0, illegal_o}, {31'd0, m_ill});
        chk("busy_o", {31'd0, busy_o}, {31'd0, b});
        chk("done_o", {31'd0, done_o}, {31'd0, m_valid & ~b});
        if (m_known) begin
            chk("data1_o", data1_o, m_d1);
            chk("data2_o", data2_o, m_d2);
            chk("RTdata_o", RTdata_o, m_rt);
        end
    endtask

    task automatic cycle();
        logic [3:0] e;
        bit b;
        b = m_busy();
        e = ref_encode(ALUOp_i, funct_i);
        if (rst_i) begin
            m_valid = 0; m_ctrl = 0; m_ill = 0; m_d1 = 0; m_d2 = 0; m_rt = 0;
            m_known = 1; m_window = 0; m_age = 0;
        end else if (flush_i) begin
            m_valid = 0; m_ctrl = 0; m_ill = 0; m_known = 0; m_window = 0;
        end else if (stall_i || b) begin
            m_age++;
        end else begin
            m_valid  = valid_i;
            m_ctrl   = valid_i ? e[2:0] : 3'b000;
            m_ill    = valid_i & e[3];
            m_d1     = RSdata_i;
            m_d2     = ALUSrc_i ? imm_i : RTdata_i;
            m_rt     = RTdata_i;
            m_known  = 1;
            m_window = valid_i && (e[2:0] == 3'b100);
            m_age    = 0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f, input logic src,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] im);
        valid_i = v; ALUOp_i = op; funct_i = f; ALUSrc_i = src;
        RSdata_i = rs; RTdata_i = rt; imm_i = im;
    endtask

    initial begin
        logic [5:0] functs [6];
        functs[0] = 6'h24; functs[1] = 6'h25; functs[2] = 6'h20;
        functs[3] = 6'h22; functs[4] = 6'h18; functs[5] = 6'h2A;
        m_known = 0; m_window = 0; m_age = 0;
        m_valid = 0; m_ctrl = 0; m_ill = 0; m_d1 = 0; m_d2 = 0; m_rt = 0;
        rst_i = 1; stall_i = 0; flush_i = 0;
        drive(1, 2'd2, 6'h18, 0, 32'hDEAD, 32'hBEEF, 32'h1);
`ifdef ALU_ISSUE_FORWARD_EN
        fwdA_i = 0; fwdB_i = 0; EXMEM_data_i = 0; MEMWB_data_i = 0;
`endif
        // Reset
        cycle();
        cycle();
        chk("reset_data1", data1_o, 32'd0);
        rst_i = 0;

        // R-type sub
        drive(1, 2'd2, 6'h22, 0, 32'd7, 32'd3, 32'd99);
        cycle();
        chk("rtype_ctrl", {29'd0, ALUCtrl_o}, 32'd3);
        chk("rtype_data1", data1_o, 32'd7);
        chk("rtype_data2", data2_o, 32'd3);
        chk("rtype_done", {31'd0, done_o}, 32'd1);

        // Immediate add
        drive(1, 2'd0, 6'h00, 1, 32'd5, 32'd9, 32'hFFFFFFFC);
        cycle();
        chk("imm_data2", data2_o, 32'hFFFFFFFC);
        chk("imm_illegal", {31'd0, illegal_o}, 32'd0);

        // Multi-cycle mul followed by an add
        drive(1, 2'd2, 6'h18, 0, 32'd6, 32'd7, 32'd0);
        cycle();
        chk("mul_busy1", {31'd0, busy_o}, 32'd1);
        drive(1, 2'd0, 6'h00, 1, 32'd10, 32'd11, 32'd20);
        cycle();
        chk("mul_busy2", {31'd0, busy_o}, 32'd1);
        cycle();
        chk("mul_done3", {31'd0, done_o}, 32'd1);
        chk("mul_data1_3", data1_o, 32'd6);
        cycle();
        chk("add_after_mul", {29'd0, ALUCtrl_o}, 32'd2);

        // Flush on the second busy cycle
        drive(1, 2'd2, 6'h18, 0, 32'd2, 32'd4, 32'd0);
        cycle();
        cycle();
        flush_i = 1;
        cycle();
        chk("flush_busy", {31'd0, busy_o}, 32'd0);
        chk("flush_valid", {31'd0, valid_o}, 32'd0);
        flush_i = 0;

        // Stall across the mul window plus two extra cycles
        drive(1, 2'd2, 6'h18, 0, 32'd3, 32'd5, 32'd0);
        cycle();
        stall_i = 1;
        drive(1, 2'd2, 6'h25, 0, 32'd1, 32'd2, 32'd0);
        for (int i = 0; i < 4; i++) cycle();
        chk("stall_hold_mul", {29'd0, ALUCtrl_o}, 32'd4);
        stall_i = 0;
        cycle();
        chk("stall_release", {29'd0, ALUCtrl_o}, 32'd1);

        // Illegal encodings and a bubble carrying a mul funct
        drive(1, 2'd2, 6'h2A, 0, 32'd1, 32'd1, 32'd0);
        cycle();
        chk("illegal_funct", {31'd0, illegal_o}, 32'd1);
        drive(1, 2'd3, 6'h20, 0, 32'd1, 32'd1, 32'd0);
        cycle();
        drive(0, 2'd2, 6'h18, 0, 32'd1, 32'd1, 32'd0);
        cycle();
        chk("bubble_busy", {31'd0, busy_o}, 32'd0);

`ifdef ALU_ISSUE_FORWARD_EN
        drive(1, 2'd2, 6'h20, 0, 32'd8, 32'd9, 32'd0);
        cycle();
        fwdA_i = 2'b10; EXMEM_data_i = 32'h1234; fwdB_i = 2'b01; MEMWB_data_i = 32'h5678;
        #1;
        chk("fwd_data1", data1_o, 32'h1234);
        chk("fwd_data2", data2_o, 32'h5678);
        chk("fwd_rt", RTdata_o, 32'h5678);
        fwdA_i = 2'b11; fwdB_i = 2'b11;
        #1;
        chk("fwd11_data1", data1_o, 32'd8);
        fwdA_i = 0; fwdB_i = 0;
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst_i   = ($urandom % 64) == 0;
            flush_i = ($urandom % 10) == 0;
            stall_i = ($urandom % 4) == 0;
            drive(($urandom % 4) != 0, 2'($urandom % 4),
                  (($urandom % 2) == 0) ? functs[$urandom % 6] : 6'($urandom),
                  1'($urandom), $urandom, $urandom, $urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX-side issue register that drives the EX-stage ALU in the pipelined CPU.
- Encodes ALUOp/funct into the 3-bit ALU control code and registers operands.
- Selects the second operand (register or immediate).
- Holds mul operations stable for a multi-cycle window, and tells upstream logic when to stall.

Parameters:
- MUL_LATENCY, 3, cycles a mul must be held at the ALU inputs. Legal range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  ID stage presents an instruction
- stall_i  in  1  hazard-unit stall; hold the current contents
- flush_i  in  1  insert bubble (branch taken)
- ALUOp_i  in  2  00 add (lw/sw/addi), 01 sub (beq), 10 R-type, 11 reserved
- funct_i  in  6  R-type funct field
- ALUSrc_i  in  1  1 = use imm_i as operand 2
- RSdata_i  in  32  rs register value
- RTdata_i  in  32  rt register value
- imm_i  in  32  sign-extended immediate
- data1_o  out  32  ALU operand 1
- data2_o  out  32  ALU operand 2
- ALUCtrl_o  out  3  000 and, 001 or, 010 add, 011 sub, 100 mul
- RTdata_o  out  32  registered rt value (store data)
- valid_o  out  1  entry in EX is a real instruction
- busy_o  out  1  mul hold in progress; upstream must stall
- done_o  out  1  valid_o & ~busy_o; EX result may be captured
- illegal_o  out  1  registered; unknown funct or ALUOp=11

Behaviour:
- Reset: all outputs 0. The mul counter cnt (4 bits) is 0.
- Encoding is combinational on the inputs and registered together with the entry.
  - ALUOp 00 → 010; ALUOp 01 → 011.
  - ALUOp 10 with funct: 0x24 → 000, 0x25 → 001, 0x20 → 010, 0x22 → 011, 0x18 → 100.
  - Any other funct, or ALUOp 11 → 010, with illegal=1.
- Update priority per rising edge: rst_i > flush_i > hold > load.
  - hold = stall_i | busy_o.
  - flush: valid_o ← 0, ALUCtrl_o ← 000, illegal_o ← 0, cnt ← 0. Data outputs are don't-care.
  - hold: all registers keep their value; cnt still counts.
  - load: data1_o ← RSdata_i; data2_o ← ALUSrc_i ? imm_i : RSdata_i→ no, data2_o ← ALUSrc_i ? imm_i : RTdata_i.
  - load (continued): RTdata_o ← RTdata_i; valid_o ← valid_i; ALUCtrl_o and illegal_o ← encoded values.
  - Load with valid_i=0 produces a bubble (valid_o=0, ALUCtrl_o=000).
- Mul window:
  - On a load with valid_i=1, code 100, and MUL_LATENCY>1: cnt ← MUL_LATENCY-1.
  - Otherwise on load: cnt ← 0.
  - While cnt≠0: cnt decrements by 1 every cycle, independent of stall_i.
  - busy_o = (cnt≠0), combinational from cnt.
  - A mul therefore occupies EX for exactly MUL_LATENCY cycles. done_o rises in the last cycle.
  - MUL_LATENCY=1: busy_o never asserts.
- Flush during busy: window aborted. busy_o=0 next cycle.
- stall_i and busy_o together: the entry is held. When cnt reaches 0 while stall_i=1, the entry keeps holding with done_o=1 until stall_i drops.
- Back-to-back muls: the second loads on the first cycle where busy_o=0 and stall_i=0. No gap cycle is inserted.
- Width: all operands pass through unmodified at 32 bits. No extension is done here.

Optional Feature:
- Macro: ALU_ISSUE_FORWARD_EN.
- Defined adds these ports:
  - fwdA_i[1:0], fwdB_i[1:0]
  - EXMEM_data_i[31:0], MEMWB_data_i[31:0]
- Defined, forwarding selection:
  - Code 00 selects the registered value, 10 selects EXMEM_data_i, 01 selects MEMWB_data_i, 11 behaves as 00.
  - data1_o is combinationally selected by fwdA_i.
  - For rt: selected by fwdB_i; the result drives RTdata_o.
  - data2_o = registered imm if the latched ALUSrc=1, else the forwarded rt.
- Not defined: the ports are absent and outputs come straight from the registers, as in the base behaviour.

Test Plan:
- Reset, then R-type: rst_i=1 for 2 cycles → all outputs 0. Then ALUOp=10, funct=0x22, RS=7, RT=3, valid=1 → next cycle ALUCtrl_o=011, data1_o=7, data2_o=3, valid_o=1, done_o=1.
- Immediate: ALUOp=00, ALUSrc=1, RS=5, imm=0xFFFFFFFC → data2_o=0xFFFFFFFC, ALUCtrl_o=010, illegal_o=0.
- Multi-cycle mul: MUL_LATENCY=3, funct=0x18 loaded with RS=6, RT=7 → busy_o=1 for 2 cycles, operands stable 3 cycles, done_o=1 in the 3rd cycle. A following add loads on the 4th cycle.
- Flush mid-mul: flush_i=1 on the 2nd busy cycle → next cycle valid_o=0, busy_o=0, ALUCtrl_o=000.
- Stall vs busy: stall_i=1 across the whole mul window plus 2 extra cycles → the mul stays held with done_o=1 in the last 3 cycles. No new load until stall_i=0.
- Illegal encoding: ALUOp=10, funct=0x2A → ALUCtrl_o=010, illegal_o=1. With ALU_ISSUE_FORWARD_EN: fwdA=10, EXMEM=0x1234 → data1_o=0x1234 in the same cycle.
